alu_result_fifo: RTL and testbench
==================================

# alu_result_fifo

Buffered result stage directly downstream of the combinational 3-bit ALU. It captures each ALU transaction (operation select, both operands, signed result) over a valid/ready handshake and derives status flags per entry: zero, negative, and divide/modulo-by-zero. Entries are queued in a small first-word-fall-through FIFO and presented to the consumer over a second valid/ready handshake. It decouples the ALU's zero-latency output from a consumer that may stall.

## Interface
- DATA_WIDTH, 3: operand width; result width is 2*DATA_WIDTH+1.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream presents an ALU transaction.
- in_ready  output  1  stage can accept; equals !full.
- in_sel  input  3  ALU operation select (0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 mod).
- in_a  input  DATA_WIDTH  ALU operand in0, unsigned.
- in_b  input  DATA_WIDTH  ALU operand in1, unsigned.
- in_result  input  2*DATA_WIDTH+1  ALU output, two's complement.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head entry.
- out_sel, out_a, out_b, out_result  output  same widths as inputs  head entry fields.
- out_zero  output  1  head result == 0.
- out_neg  output  1  head result MSB.
- out_dz  output  1  head entry was div/mod with in_b == 0.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- dz_count  output  8  saturating count of accepted dz entries.

## Operation
- Push: in_valid && in_ready at a rising edge writes {in_sel, in_a, in_b, in_result, zero, neg, dz} at the write pointer.
- Pop: out_valid && out_ready at a rising edge retires the head entry.
- Flags are computed from the input fields at push and stored with the entry; they are never recomputed.
- dz = (in_sel == 3 || in_sel == 7) && in_b == 0. in_result is stored as given; the ALU drives 0 in that case.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. count tracks occupancy: push only → +1; pop only → −1; both → unchanged.
- full = (count == DEPTH). empty = (count == 0). out_valid = !empty.
- No bypass: a push into an empty FIFO is not visible on out_* until the next cycle, and in_ready stays low while full even if out_ready = 1.
- Push ignored when in_ready = 0. Pop ignored when out_valid = 0. Neither case changes any state.
- dz_count increments on each accepted push with dz = 1 and saturates at 255. It clears only on reset.
- out_* data fields are don't-care while out_valid = 0, but are driven to 0 after reset.
- Control states are implied by count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH). Transitions occur only via push or pop as above.

## Timing
- Reset, sampled with rst_n = 0 at a rising edge:
  - count = 0, both pointers = 0, out_valid = 0, in_ready = 1.
  - out_* data and flags = 0; dz_count = 0.
  - Storage contents need not clear.
- Reset mid-operation discards all queued entries. A push or pop in the reset cycle has no effect.
- Latency: an entry pushed at edge N is valid on out_* after edge N, at the earliest, when the FIFO was empty.
- Throughput: one push and one pop per cycle, sustained, while the FIFO is neither empty nor full.
- in_ready and out_valid are functions of registered state only; there is no combinational path from in_valid or out_ready.
- Upstream must hold its inputs stable while in_valid && !in_ready. The consumer may deassert out_ready at any cycle.

## Test plan
- Basic add: reset, then push sel=0, a=3, b=5, result=8 → one cycle later out_valid=1, out_result=8, zero=0, neg=0, dz=0, count=1. Pop → out_valid=0, count=0.
- Negative subtract: push sel=1, a=2, b=5, result=−3 (7'b1111101) → out_neg=1, out_zero=0, out_result=−3.
- Divide and modulo by zero: push sel=3, a=6, b=0, result=0, then sel=7, a=4, b=0, result=0 → both entries show zero=1 and dz=1; dz_count=2. Push sel=3, a=6, b=2, result=3 → dz=0; dz_count stays 2.
- Full and wrap: with out_ready=0, push 4 entries → count=4, in_ready=0. A 5th push is ignored. Pop all 4 → entries emerge in order. Push and pop 8 more → pointer wrap with order preserved.
- Simultaneous push and pop: at count=2 with in_valid=1 and out_ready=1 for 3 cycles → count stays 2 and output order matches input order. At count=4 with both asserted → pop only, count=3.
- Reset mid-operation at count=3 with dz_count=5: hold rst_n=0 for 1 cycle → count=0, out_valid=0, dz_count=0, in_ready=1. Drive 260 dz pushes with out_ready=1 → dz_count saturates at 255.

Source files
------------

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - buffered ALU result stage with per-entry status flags
//
// Captures ALU transactions over a valid/ready handshake. Each entry is stored
// with its zero, negative and divide/modulo-by-zero flags. Entries are queued in
// a first-word-fall-through FIFO and presented to a consumer over a second
// valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready = !full)
//   in_sel, in_a, in_b    ALU select and operands
//   in_result             ALU result, two's complement, 2*DATA_WIDTH+1 bits
//   out_valid / out_ready consumer handshake (out_valid = !empty)
//   out_sel .. out_result head entry fields (0 while empty)
//   out_zero, out_neg     head result is zero / negative
//   out_dz                head entry was div/mod with in_b == 0
//   count                 occupancy, 0..DEPTH
//   dz_count              saturating count of accepted dz entries

module alu_result_fifo #(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [2:0]                          in_sel,
  input  logic [DATA_WIDTH-1:0]               in_a,
  input  logic [DATA_WIDTH-1:0]               in_b,
  input  logic [2*DATA_WIDTH:0]               in_result,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [2:0]                          out_sel,
  output logic [DATA_WIDTH-1:0]               out_a,
  output logic [DATA_WIDTH-1:0]               out_b,
  output logic [2*DATA_WIDTH:0]               out_result,
  output logic                                out_zero,
  output logic                                out_neg,
  output logic                                out_dz,
  output logic [$clog2(DEPTH):0]              count,
  output logic [7:0]                          dz_count
);

  localparam int RW = 2*DATA_WIDTH+1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW+1;

  localparam logic [2:0] SEL_DIV = 3'd3;
  localparam logic [2:0] SEL_MOD = 3'd7;

  typedef struct packed {
    logic [2:0]            sel;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [RW-1:0]         result;
    logic                  zero;
    logic                  neg;
    logic                  dz;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic   push;
  logic   pop;
  logic   in_dz;
  entry_t in_entry;
  entry_t head;

  // Handshake outputs depend only on the registered occupancy, so there is no
  // combinational path from in_valid or out_ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign in_dz = ((in_sel == SEL_DIV) || (in_sel == SEL_MOD)) && (in_b == '0);

  always_comb begin
    in_entry        = '0;
    in_entry.sel    = in_sel;
    in_entry.a      = in_a;
    in_entry.b      = in_b;
    in_entry.result = in_result;
    in_entry.zero   = (in_result == '0);
    in_entry.neg    = in_result[RW-1];
    in_entry.dz     = in_dz;
  end

  // Storage is never cleared, so the head is masked while empty; this keeps
  // out_* at zero after reset.
  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem[rd_ptr];
    end
  end

  assign out_sel    = head.sel;
  assign out_a      = head.a;
  assign out_b      = head.b;
  assign out_result = head.result;
  assign out_zero   = head.zero;
  assign out_neg    = head.neg;
  assign out_dz     = head.dz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dz_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        // DEPTH is a power of two, so the pointer wraps naturally.
        wr_ptr      <= wr_ptr + 1'b1;
        if (in_dz && (dz_count != 8'hFF)) begin
          dz_count <= dz_count + 8'd1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - scoreboard testbench for alu_result_fifo

module tb_alu_result_fifo;

  localparam int DW    = 3;
  localparam int DEPTH = 4;
  localparam int RW    = 2*DW+1;
  localparam int CW    = $clog2(DEPTH)+1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_sel = '0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [RW-1:0] in_result = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    out_sel;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic [RW-1:0] out_result;
  logic          out_zero;
  logic          out_neg;
  logic          out_dz;
  logic [CW-1:0] count;
  logic [7:0]    dz_count;

  alu_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_result  (in_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sel    (out_sel),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_dz     (out_dz),
    .count      (count),
    .dz_count   (dz_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    sel;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] result;
  } txn_t;

  txn_t q[$];
  int   mdz;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] alu(input logic [2:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int r;
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    case (s)
      3'd0: r = ia + ib;
      3'd1: r = ia - ib;
      3'd2: r = ia * ib;
      3'd3: r = (ib == 0) ? 0 : ia / ib;
      3'd4: r = ia & ib;
      3'd5: r = ia | ib;
      3'd6: r = ia ^ ib;
      default: r = (ib == 0) ? 0 : ia % ib;
    endcase
    return r[RW-1:0];
  endfunction

  // One clock: drive inputs, check the DUT on the falling edge against the
  // model, then advance the model on the rising edge.
  task automatic step(input logic iv, input logic orr, input logic [2:0] s,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic do_push;
    logic do_pop;
    logic edz;
    txn_t t;
    txn_t h;
    in_valid  = iv;
    out_ready = orr;
    in_sel    = s;
    in_a      = a;
    in_b      = b;
    in_result = alu(s, a, b);
    @(negedge clk);
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("dz_count", 32'(dz_count), 32'(mdz));
    if (q.size() != 0) begin
      h = q[0];
      chk("out_sel", 32'(out_sel), 32'(h.sel));
      chk("out_a", 32'(out_a), 32'(h.a));
      chk("out_b", 32'(out_b), 32'(h.b));
      chk("out_result", 32'(out_result), 32'(h.result));
      chk("out_zero", 32'(out_zero), 32'(h.result == '0));
      chk("out_neg", 32'(out_neg), 32'(h.result[RW-1]));
      chk("out_dz", 32'(out_dz), 32'(((h.sel == 3'd3) || (h.sel == 3'd7)) && (h.b == '0)));
    end
    do_push = iv && (q.size() != DEPTH);
    do_pop  = orr && (q.size() != 0);
    edz     = ((s == 3'd3) || (s == 3'd7)) && (b == '0);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      t.sel = s; t.a = a; t.b = b; t.result = alu(s, a, b);
      q.push_back(t);
      if (edz && mdz < 255) mdz++;
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_sel    = 3'd3;
    in_a      = 3'd1;
    in_b      = 3'd0;
    in_result = '0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    q.delete();
    mdz = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 3'd0, '0, '0);
  endtask

  initial begin
    mdz = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dz_count", 32'(dz_count), 32'd0);
    chk("rst_out_data", {out_sel, out_a, out_b, out_result}, 32'd0);
    chk("rst_out_flags", {out_zero, out_neg, out_dz}, 32'd0);

    // Basic add: visible one cycle after the push, no bypass.
    step(1, 0, 3'd0, 3'd3, 3'd5);
    chk("add_result", 32'(out_result), 32'd8);
    chk("add_flags", {out_zero, out_neg, out_dz}, 32'd0);
    chk("add_count", 32'(count), 32'd1);
    step(0, 1, 3'd0, '0, '0);
    chk("add_pop_valid", 32'(out_valid), 32'd0);

    // Negative subtract.
    step(1, 0, 3'd1, 3'd2, 3'd5);
    chk("sub_result", 32'(out_result), 32'b1111101);
    chk("sub_neg", 32'(out_neg), 32'd1);
    chk("sub_zero", 32'(out_zero), 32'd0);
    drain();

    // Divide and modulo by zero.
    step(1, 0, 3'd3, 3'd6, 3'd0);
    step(1, 0, 3'd7, 3'd4, 3'd0);
    chk("dz_count_2", 32'(dz_count), 32'd2);
    chk("div0_flags", {out_zero, out_dz}, 32'b11);
    step(1, 0, 3'd3, 3'd6, 3'd2);
    chk("dz_count_hold", 32'(dz_count), 32'd2);
    drain();

    // Full, ignored 5th push, in-order drain, then wrap.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 3'(i), 3'(i + 1), 3'(i + 2));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step(1, 1, 3'd6, 3'd7, 3'd7);
    chk("full_no_bypass", 32'(count), 32'd3);
    drain();
    for (int i = 0; i < 8; i++) step(1, 1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    drain();

    // Simultaneous push and pop at count=2, then at full.
    step(1, 0, 3'd2, 3'd7, 3'd7);
    step(1, 0, 3'd5, 3'd2, 3'd4);
    for (int i = 0; i < 3; i++) step(1, 1, 3'd6, 3'(i), 3'd5);
    chk("pp_count", 32'(count), 32'd2);
    step(1, 0, 3'd4, 3'd7, 3'd3);
    step(1, 0, 3'd0, 3'd7, 3'd7);
    step(1, 1, 3'd1, 3'd0, 3'd7);
    chk("full_pp_count", 32'(count), 32'd3);
    drain();

    // Random traffic.
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)));
    drain();

    // Reset mid-operation at count=3, dz_count=5.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 3'd7, 3'(i), 3'd0);
    step(1, 1, 3'd3, 3'd5, 3'd0);
    step(1, 1, 3'd3, 3'd5, 3'd0);
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_dz", 32'(dz_count), 32'd5);
    do_reset();
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_dz", 32'(dz_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);

    // Saturation of dz_count.
    for (int i = 0; i < 260; i++) step(1, 1, ((i % 2) == 0) ? 3'd3 : 3'd7, 3'(i), 3'd0);
    chk("dz_sat", 32'(dz_count), 32'd255);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
